mult_wb_sequencer: RTL and testbench
====================================

# mult_wb_sequencer

Controls the 32-bit register file's write port for multiply instructions. It runs a radix-2 shift-add 32×32 multiply over multiple cycles and stalls the pipeline while it runs. It then issues the single two-word write that lands the product in r19 (low) and r20 (high). Outside that write it passes normal ALU writebacks straight to the register file. A one-entry buffer replays any ALU write that collides with the product write.

## Interface
- No parameters; width fixed at 32.
- clk  in  1  system clock; register file writes on negedge, this block updates on posedge
- rst  in  1  asynchronous, active-high reset
- start  in  1  issue request; honoured only in IDLE with a multiply code on alu_control_in
- alu_control_in  in  4  operation code; 4'b0001 unsigned multiply, 4'b0010 signed multiply
- op_a, op_b  in  32  multiplicand, multiplier
- alu_wren  in  1  ALU writeback request
- alu_waddr  in  5  ALU destination register
- alu_wdata  in  32  ALU result
- stall  out  1  pipeline hold
- busy  out  1  multiply in progress
- done  out  1  one-cycle pulse coincident with the product write
- wren  out  1  register-file write enable
- waddr  out  5  register-file write address
- wdata0, wdata1  out  32  low / high write data
- alu_control  out  4  drives the register file's mult_signal input

## Operation
- States: IDLE, RUN, FIX, WRITE, REPLAY.
- IDLE:
  - Combinational pass-through: wren=alu_wren, waddr=alu_waddr, wdata0=alu_wdata, wdata1=0, alu_control=4'b0000.
  - start with code 0001/0010: latch the code. Latch |op_a| and |op_b|; the signed case records sign = op_a[31]^op_b[31]. Clear the 64-bit accumulator and the counter. Go to RUN.
  - start with any other code is ignored.
- RUN, one iteration per cycle:
  - If multiplier bit0 = 1, add the shifted multiplicand into the accumulator.
  - Shift the multiplicand left and the multiplier right; increment the counter.
  - Exit to FIX when counter = 32.
- FIX: if signed and sign = 1, negate the 64-bit accumulator (two's complement). Go to WRITE.
- WRITE:
  - Outputs: wren=1, alu_control=latched code, wdata0=acc[31:0], wdata1=acc[63:32], waddr=5'd19, done=1.
  - If alu_wren = 1 this cycle, capture the ALU write into the replay buffer and go to REPLAY. Otherwise go to IDLE.
- REPLAY: drive the buffered write with alu_control=4'b0000, then go to IDLE.
- stall = (IDLE & start & multiply code) | busy | (state==REPLAY). It is combinational, so it asserts in the issue cycle.
- busy = state ∈ {RUN, FIX, WRITE}.
- Arithmetic: magnitudes are 32-bit unsigned. abs(0x80000000) is 0x80000000 treated as unsigned, which is correct. Accumulator is 64-bit with no overflow.
- start while busy or in REPLAY is ignored.
- rst asserted in any state → IDLE immediately; no product write is issued and the replay buffer is discarded.

## Timing
- Reset values: stall=0, busy=0, done=0, wren=0, waddr=0, wdata0=0, wdata1=0, alu_control=0. alu_wren is forced low internally while rst is high.
- Issue edge = E0. RUN covers E1–E32, FIX is entered after E32, WRITE after E33. The product write is therefore visible in the cycle after E33, and the register file commits it on that cycle's negedge.
- Issue-to-write latency is 34 cycles; a REPLAY adds one cycle.
- Back-to-back multiplies: the next start is accepted in the first IDLE cycle, with a minimum of 35 cycles between issues.

## Configuration
- MULT_EARLY_TERM_EN:
  - Defined: RUN also exits to FIX when the shifted multiplier becomes 0 after an iteration. RUN lasts at least 1 cycle, so op_b=0 gives a 1-cycle RUN.
  - Undefined: RUN always lasts exactly 32 cycles.
  - The product is identical either way.

## Structure
- Shared package kgp_risc_pkg holds:
  - ALU_MULTU=4'b0001, ALU_MULT=4'b0010.
  - HI_REG=5'd20, LO_REG=5'd19.
  - The state enum for this block.
- Sub-module mult_shift_add holds the accumulator, the shift registers, the counter and the negation. The controller keeps the state machine, the arbitration and the replay buffer.

## Test plan
- Unsigned 0xFFFFFFFF×0xFFFFFFFF → wdata1=0xFFFFFFFE, wdata0=0x00000001, alu_control=0001, wren one cycle, 34 cycles after issue, macro undefined.
- Signed (-3)×7 → wdata1=0xFFFFFFFF, wdata0=0xFFFFFFEB; signed 0x80000000×0x80000000 → wdata1=0x40000000, wdata0=0.
- alu_wren=1 with waddr=5, data=0x1234 during WRITE → next cycle wren=1, waddr=5, wdata0=0x1234, alu_control=0000; stall held through REPLAY.
- rst pulsed 10 cycles after issue → all outputs 0 immediately, no write to r19/r20; a fresh multiply afterwards completes correctly.
- MULT_EARLY_TERM_EN defined, unsigned 5×3 → RUN lasts 2 cycles, write at issue+4, wdata0=15, wdata1=0.
- start with code 4'b0000 or start while busy → ignored; stall reflects only the active operation, and pass-through writes are unaffected in IDLE.

Source files
------------

// File: rtl/kgp_risc_pkg.sv
// Shared constants, state encoding and helpers for the multiply writeback sequencer.
package kgp_risc_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ACC_W = 64;
    localparam int unsigned CNT_W = 6;

    localparam logic [3:0] ALU_NOP   = 4'b0000;
    localparam logic [3:0] ALU_MULTU = 4'b0001;
    localparam logic [3:0] ALU_MULT  = 4'b0010;

    localparam logic [4:0] HI_REG = 5'd20;
    localparam logic [4:0] LO_REG = 5'd19;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_FIX    = 3'd2,
        ST_WRITE  = 3'd3,
        ST_REPLAY = 3'd4
    } mult_state_e;

    function automatic logic is_mult_code(input logic [3:0] code);
        return (code == ALU_MULTU) || (code == ALU_MULT);
    endfunction

    // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [XLEN-1:0] abs32(input logic [XLEN-1:0] x);
        return x[XLEN-1] ? (~x + XLEN'(1)) : x;
    endfunction

endpackage

// File: rtl/mult_shift_add.sv
// Radix-2 shift-add 32x32 multiplier datapath: accumulator, shift registers, counter, sign fix.
// MULT_EARLY_TERM_EN: also flag the last iteration once the remaining multiplier is zero.
module mult_shift_add
    import kgp_risc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_fix,
    input  logic             i_signed,
    input  logic [XLEN-1:0]  i_op_a,
    input  logic [XLEN-1:0]  i_op_b,
    output logic [ACC_W-1:0] o_acc,
    output logic             o_last_c
);

    logic [ACC_W-1:0] r_mcand;
    logic [XLEN-1:0]  r_mplier;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_count;
    logic             r_neg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_neg    <= 1'b0;
        end else if (i_load) begin
            r_mcand  <= ACC_W'(i_signed ? abs32(i_op_a) : i_op_a);
            r_mplier <= i_signed ? abs32(i_op_b) : i_op_b;
            r_acc    <= '0;
            r_count  <= '0;
            r_neg    <= i_signed & (i_op_a[XLEN-1] ^ i_op_b[XLEN-1]);
        end else if (i_step) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + CNT_W'(1);
        end else if (i_fix && r_neg) begin
            r_acc <= ~r_acc + ACC_W'(1);
        end
    end

    // Current iteration is the last one: counter reaches 32 after it (or nothing left to add).
`ifdef MULT_EARLY_TERM_EN
    assign o_last_c = (r_count == CNT_W'(XLEN - 1)) || (r_mplier[XLEN-1:1] == '0);
`else
    assign o_last_c = (r_count == CNT_W'(XLEN - 1));
`endif

    assign o_acc = r_acc;

endmodule

// File: rtl/mult_wb_sequencer.sv
// Register-file write-port sequencer: multi-cycle multiply, product write to r19/r20, ALU replay.
// MULT_EARLY_TERM_EN (optional) shortens RUN once the multiplier is exhausted.
module mult_wb_sequencer
    import kgp_risc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [3:0]      alu_control_in,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            alu_wren,
    input  logic [4:0]      alu_waddr,
    input  logic [XLEN-1:0] alu_wdata,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic            wren,
    output logic [4:0]      waddr,
    output logic [XLEN-1:0] wdata0,
    output logic [XLEN-1:0] wdata1,
    output logic [3:0]      alu_control
);

    mult_state_e      r_state;
    mult_state_e      w_state_next;
    logic [3:0]       r_code;
    logic [4:0]       r_rp_addr;
    logic [XLEN-1:0]  r_rp_data;

    logic             w_start;
    logic             w_alu_wren;
    logic [4:0]       w_alu_waddr;
    logic [XLEN-1:0]  w_alu_wdata;
    logic             w_issue;
    logic             w_load;
    logic             w_step;
    logic             w_fix;
    logic             w_capture;
    logic             w_last;
    logic [ACC_W-1:0] w_acc;

    // Reset masks the request inputs so every output reads zero while rst is high.
    assign w_start     = start & ~rst;
    assign w_alu_wren  = alu_wren & ~rst;
    assign w_alu_waddr = rst ? 5'd0 : alu_waddr;
    assign w_alu_wdata = rst ? '0 : alu_wdata;
    assign w_issue     = (r_state == ST_IDLE) && w_start && is_mult_code(alu_control_in);

    mult_shift_add u_mult (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_fix    (w_fix),
        .i_signed (alu_control_in == ALU_MULT),
        .i_op_a   (op_a),
        .i_op_b   (op_b),
        .o_acc    (w_acc),
        .o_last_c (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_code    <= ALU_NOP;
            r_rp_addr <= '0;
            r_rp_data <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_issue) begin
                r_code <= alu_control_in;
            end
            if (w_capture) begin
                r_rp_addr <= w_alu_waddr;
                r_rp_data <= w_alu_wdata;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_fix        = 1'b0;
        w_capture    = 1'b0;
        done         = 1'b0;
        wren         = 1'b0;
        waddr        = 5'd0;
        wdata0       = '0;
        wdata1       = '0;
        alu_control  = ALU_NOP;

        case (r_state)
            ST_IDLE: begin
                wren   = w_alu_wren;
                waddr  = w_alu_waddr;
                wdata0 = w_alu_wdata;
                if (w_issue) begin
                    w_load       = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                w_fix        = 1'b1;
                w_state_next = ST_WRITE;
            end
            ST_WRITE: begin
                wren         = 1'b1;
                waddr        = LO_REG;
                wdata0       = w_acc[XLEN-1:0];
                wdata1       = w_acc[ACC_W-1:XLEN];
                alu_control  = r_code;
                done         = 1'b1;
                w_capture    = w_alu_wren;
                w_state_next = w_alu_wren ? ST_REPLAY : ST_IDLE;
            end
            ST_REPLAY: begin
                wren         = 1'b1;
                waddr        = r_rp_addr;
                wdata0       = r_rp_data;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        busy  = (r_state == ST_RUN) || (r_state == ST_FIX) || (r_state == ST_WRITE);
        stall = w_issue || busy || (r_state == ST_REPLAY);
    end

endmodule

// File: tb/tb_mult_wb_sequencer.sv
// Scoreboard bench for mult_wb_sequencer: product writes, pass-through, replay, reset abort.
module tb_mult_wb_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  alu_control_in;
    logic [31:0] op_a, op_b;
    logic        alu_wren;
    logic [4:0]  alu_waddr;
    logic [31:0] alu_wdata;
    logic        stall, busy, done, wren;
    logic [4:0]  waddr;
    logic [31:0] wdata0, wdata1;
    logic [3:0]  alu_control;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [3:0]  ctrl;
        logic        dn;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    always #5 clk = ~clk;

    mult_wb_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .alu_control_in (alu_control_in),
        .op_a           (op_a),
        .op_b           (op_b),
        .alu_wren       (alu_wren),
        .alu_waddr      (alu_waddr),
        .alu_wdata      (alu_wdata),
        .stall          (stall),
        .busy           (busy),
        .done           (done),
        .wren           (wren),
        .waddr          (waddr),
        .wdata0         (wdata0),
        .wdata1         (wdata1),
        .alu_control    (alu_control)
    );

    // Every register-file write must match the next scoreboard entry.
    always @(negedge clk) begin
        if (!rst && wren) begin
            wr_t got;
            wr_t e;
            got = {waddr, wdata0, wdata1, alu_control, done};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got waddr=%0d wdata0=%h wdata1=%h ctrl=%b done=%b, none expected",
                         waddr, wdata0, wdata1, alu_control, done);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL write_data: got waddr=%0d wdata0=%h wdata1=%h ctrl=%b done=%b, exp waddr=%0d wdata0=%h wdata1=%h ctrl=%b done=%b",
                             waddr, wdata0, wdata1, alu_control, done, e.addr, e.d0, e.d1, e.ctrl, e.dn);
                end
            end
        end
    end

    function automatic int lat_model(input logic [3:0] code, input logic [31:0] b);
        logic [31:0] m;
        int k;
        m = (code == 4'b0010 && b[31]) ? (~b + 32'd1) : b;
`ifdef MULT_EARLY_TERM_EN
        k = 1;
        m = m >> 1;
        while (m != 0 && k < 32) begin
            k++;
            m = m >> 1;
        end
`else
        k = 32;
`endif
        return k + 2;
    endfunction

    function automatic logic [63:0] prod_model(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb;
        if (code == 4'b0010) begin
            ea = {{32{a[31]}}, a};
            eb = {{32{b[31]}}, b};
        end else begin
            ea = {32'd0, a};
            eb = {32'd0, b};
        end
        return ea * eb;
    endfunction

    // Issue a multiply and return at the negedge of its WRITE cycle.
    task automatic do_mult(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                           input bit poke, input bit use_ref, input logic [63:0] ref_p);
        logic [63:0] p;
        int lat, n;
        bit got;
        p   = use_ref ? ref_p : prod_model(code, a, b);
        lat = lat_model(code, b);
        exp_q.push_back({5'd19, p[31:0], p[63:32], code, 1'b1});
        @(posedge clk); #1;
        start = 1'b1; alu_control_in = code; op_a = a; op_b = b;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL issue_stall: got stall=%b busy=%b, exp stall=1 busy=0", stall, busy);
        end
        @(posedge clk); #1;
        start = 1'b0; op_a = $urandom; op_b = $urandom; alu_control_in = 4'($urandom_range(0, 15));
        n = 0; got = 0;
        while (n < 45 && !got) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                n_checks++;
                if (busy !== 1'b1 || stall !== 1'b1) begin
                    n_fail++;
                    $display("FAIL run_busy: got busy=%b stall=%b, exp 1/1", busy, stall);
                end
            end
            if (poke && n == 5) begin
                start = 1'b1; alu_control_in = 4'b0001; op_a = 32'd9; op_b = 32'd9;
            end
            if (poke && n == 6) start = 1'b0;
            if (done === 1'b1) got = 1;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL mult_timeout: no done within 45 cycles, exp latency %0d", lat);
        end else if (n != lat) begin
            n_fail++;
            $display("FAIL mult_latency: got %0d cycles, exp %0d", n, lat);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; alu_control_in = 4'b0001; op_a = 32'd3; op_b = 32'd4;
        alu_wren = 1'b1; alu_waddr = 5'd7; alu_wdata = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({stall, busy, done, wren, waddr, wdata0, wdata1, alu_control} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got stall=%b busy=%b done=%b wren=%b waddr=%0d wdata0=%h wdata1=%h ctrl=%b, exp all 0",
                     stall, busy, done, wren, waddr, wdata0, wdata1, alu_control);
        end
        start = 1'b0; alu_wren = 1'b0; alu_waddr = '0; alu_wdata = '0; alu_control_in = '0;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || stall !== 1'b0 || wren !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got busy=%b stall=%b wren=%b, exp 0/0/0", busy, stall, wren);
        end
    endtask

    task automatic test_passthrough;
        @(posedge clk); #1;
        alu_wren = 1'b1; alu_waddr = 5'd3; alu_wdata = 32'h0000_ABCD;
        exp_q.push_back({5'd3, 32'h0000_ABCD, 32'd0, 4'b0000, 1'b0});
        @(posedge clk); #1;
        alu_wren = 1'b0;
    endtask

    task automatic test_unsigned;
        do_mult(4'b0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 64'hFFFF_FFFE_0000_0001);
        do_mult(4'b0001, 32'd5, 32'd3, 0, 1, 64'd15);
        do_mult(4'b0001, 32'd1234, 32'd0, 0, 0, 64'd0);
    endtask

    task automatic test_signed;
        do_mult(4'b0010, 32'hFFFF_FFFD, 32'd7, 0, 1, 64'hFFFF_FFFF_FFFF_FFEB);
        do_mult(4'b0010, 32'h8000_0000, 32'h8000_0000, 0, 1, 64'h4000_0000_0000_0000);
        do_mult(4'b0010, 32'd100, 32'hFFFF_FF9C, 0, 0, 64'd0);
    endtask

    task automatic test_back_to_back;
        do_mult(4'b0001, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 64'd0);
        do_mult(4'b0010, 32'hDEAD_BEEF, 32'h0000_1001, 0, 0, 64'd0);
    endtask

    task automatic test_replay;
        do_mult(4'b0001, 32'd6, 32'd7, 0, 0, 64'd0);
        #1;
        alu_wren = 1'b1; alu_waddr = 5'd5; alu_wdata = 32'h0000_1234;
        exp_q.push_back({5'd5, 32'h0000_1234, 32'd0, 4'b0000, 1'b0});
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL replay_stall: got stall=%b busy=%b, exp stall=1 busy=0", stall, busy);
        end
        #1;
        alu_wren = 1'b0;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL replay_exit: got stall=%b, exp 0", stall);
        end
    endtask

    task automatic test_ignored;
        @(posedge clk); #1;
        start = 1'b1; alu_control_in = 4'b0000; op_a = 32'd2; op_b = 32'd2;
        alu_wren = 1'b1; alu_waddr = 5'd9; alu_wdata = 32'h5555_AAAA;
        exp_q.push_back({5'd9, 32'h5555_AAAA, 32'd0, 4'b0000, 1'b0});
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL nonmult_stall: got stall=%b, exp 0", stall);
        end
        @(posedge clk); #1;
        start = 1'b0; alu_wren = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL nonmult_busy: got busy=%b, exp 0", busy);
        end
        do_mult(4'b0001, 32'd11, 32'd13, 1, 1, 64'd143);
    endtask

    task automatic test_reset_abort;
        @(posedge clk); #1;
        start = 1'b1; alu_control_in = 4'b0001; op_a = 32'hFFFF_0000; op_b = 32'h0000_FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({stall, busy, done, wren, waddr, wdata0, wdata1, alu_control} !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: got stall=%b busy=%b done=%b wren=%b waddr=%0d ctrl=%b, exp all 0",
                     stall, busy, done, wren, waddr, alu_control);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got busy=%b, exp 0", busy);
        end
        do_mult(4'b0010, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 0, 1, 64'd256);
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_unsigned();
        test_signed();
        test_back_to_back();
        test_replay();
        test_ignored();
        test_reset_abort();
        repeat (5) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending writes, exp 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
